// File: rtl/mau_pkg.sv
// Shared definitions for the memory access unit.
// Contents: access size encodings (also used as RAM modes), FSM state
// enumeration, maximum beat count, and small decode helpers.
package mau_pkg;

    localparam logic [1:0] SZ_WORD     = 2'b00;
    localparam logic [1:0] SZ_BYTE     = 2'b01;
    localparam logic [1:0] SZ_HALF     = 2'b10;
    localparam logic [1:0] SZ_WORD_ALT = 2'b11;

    localparam int MAX_BEATS = 4;
    localparam int BEAT_W    = $clog2(MAX_BEATS);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCESS  = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_RESP    = 2'd3
    } mau_state_e;

    // Word needs Addr[1:0]==0, half needs Addr[0]==0, bytes are always aligned.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lsbs);
        case (size)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return lsbs[0];
            default: return (lsbs != 2'b00);
        endcase
    endfunction

    // Index of the final beat: split accesses are byte beats, otherwise one beat.
    function automatic logic [BEAT_W-1:0] last_beat(input logic [1:0] size, input logic split);
        if (!split)
            return '0;
        else if (size == SZ_HALF)
            return BEAT_W'(1);
        else
            return BEAT_W'(MAX_BEATS - 1);
    endfunction

endpackage

// File: rtl/mau_load_align.sv
// Load data alignment for the memory access unit.
// Places the RAM read data into the assembly buffer (whole value for a
// single-beat access, byte lane <beat> for a split access) and produces the
// zero/sign-extended load result from the updated buffer.
// Ports:
//   asm_buf  in   current assembly buffer
//   ram_dout in   RAM read data (lane-selected, right-justified)
//   beat     in   current beat index
//   split    in   access is executed as byte beats
//   size     in   access size encoding
//   sgn      in   sign-extend byte/half results
//   buf_next out  assembly buffer after placing this beat
//   result   out  extended load result
module mau_load_align
    import mau_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] asm_buf,
    input  logic [DATA_W-1:0] ram_dout,
    input  logic [BEAT_W-1:0] beat,
    input  logic              split,
    input  logic [1:0]        size,
    input  logic              sgn,
    output logic [DATA_W-1:0] buf_next,
    output logic [DATA_W-1:0] result
);

    always_comb begin
        buf_next = asm_buf;
        if (split)
            buf_next[{beat, 3'b000} +: 8] = ram_dout[7:0];
        else
            buf_next = ram_dout;

        case (size)
            SZ_BYTE: result = {{(DATA_W-8){sgn & buf_next[7]}}, buf_next[7:0]};
            SZ_HALF: result = {{(DATA_W-16){sgn & buf_next[15]}}, buf_next[15:0]};
            default: result = buf_next;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Memory access unit: turns single CPU load/store requests into RAM cycles.
// Loads take ACCESS (address out) then CAPTURE (registered RAM data in);
// stores complete after their ACCESS beat(s). RESP pulses Done for one cycle.
// Optional feature macro MAU_SPLIT_EN: misaligned word/half accesses run as
// byte beats at Addr+k (wrapping); without it they complete with Err=1 and
// no RAM access.
// Ports:
//   CLK, RST            clock, synchronous active-high reset
//   Req, Wr, Size, Sgn  request, store/load, size, sign-extend
//   Addr, WData         byte address, right-justified store data
//   Ready, Done, Err    idle, completion pulse, misalignment error
//   RData               load result (held until next load completion)
//   RamAddr, RamMode    RAM byte address and access size
//   RamRWn, RamDin      RAM write enable (0 = write), write data
//   RamDout             RAM read data, valid one cycle after the address
module mem_access_unit
    import mau_pkg::*;
#(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              Req,
    input  logic              Wr,
    input  logic [1:0]        Size,
    input  logic              Sgn,
    input  logic [ADDR_W-1:0] Addr,
    input  logic [DATA_W-1:0] WData,
    output logic              Ready,
    output logic              Done,
    output logic              Err,
    output logic [DATA_W-1:0] RData,
    output logic [ADDR_W-1:0] RamAddr,
    output logic [1:0]        RamMode,
    output logic              RamRWn,
    output logic [DATA_W-1:0] RamDin,
    input  logic [DATA_W-1:0] RamDout
);

    mau_state_e        state;
    logic [BEAT_W-1:0] beat;
    logic              wr_q;
    logic [1:0]        size_q;
    logic              sgn_q;
    logic              split_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] asm_buf;

    logic              req_mis;
    logic [BEAT_W-1:0] beat_nxt;
    logic              at_last;
    logic [DATA_W-1:0] buf_next;
    logic [DATA_W-1:0] load_result;

    assign req_mis  = is_misaligned(Size, Addr[1:0]);
    assign beat_nxt = beat + BEAT_W'(1);
    assign at_last  = (beat == last_beat(size_q, split_q));

    // Store data for one beat: the whole word, or byte k right-justified.
    function automatic logic [DATA_W-1:0] beat_din(input logic [DATA_W-1:0] wd,
                                                   input logic [BEAT_W-1:0] k,
                                                   input logic split);
        logic [7:0] b;
        b = wd[{k, 3'b000} +: 8];
        return split ? {{(DATA_W-8){1'b0}}, b} : wd;
    endfunction

    mau_load_align #(.DATA_W(DATA_W)) u_align (
        .asm_buf  (asm_buf),
        .ram_dout (RamDout),
        .beat     (beat),
        .split    (split_q),
        .size     (size_q),
        .sgn      (sgn_q),
        .buf_next (buf_next),
        .result   (load_result)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= ST_IDLE;
            beat    <= '0;
            wr_q    <= 1'b0;
            size_q  <= SZ_WORD;
            sgn_q   <= 1'b0;
            split_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            asm_buf <= '0;
            Ready   <= 1'b1;
            Done    <= 1'b0;
            Err     <= 1'b0;
            RData   <= '0;
            RamAddr <= '0;
            RamMode <= SZ_WORD;
            RamRWn  <= 1'b1;
            RamDin  <= '0;
        end else begin
            Done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (Req) begin
                        wr_q    <= Wr;
                        size_q  <= Size;
                        sgn_q   <= Sgn;
                        addr_q  <= Addr;
                        wdata_q <= WData;
                        beat    <= '0;
                        Ready   <= 1'b0;
`ifdef MAU_SPLIT_EN
                        split_q <= req_mis;
                        state   <= ST_ACCESS;
                        RamAddr <= Addr;
                        RamMode <= req_mis ? SZ_BYTE : Size;
                        RamRWn  <= ~Wr;
                        RamDin  <= Wr ? beat_din(WData, '0, req_mis) : '0;
`else
                        split_q <= 1'b0;
                        if (req_mis) begin
                            // Rejected without touching the RAM.
                            state <= ST_RESP;
                            Done  <= 1'b1;
                            Err   <= 1'b1;
                        end else begin
                            state   <= ST_ACCESS;
                            RamAddr <= Addr;
                            RamMode <= Size;
                            RamRWn  <= ~Wr;
                            RamDin  <= Wr ? WData : '0;
                        end
`endif
                    end
                end

                ST_ACCESS: begin
                    if (wr_q) begin
                        if (at_last) begin
                            state  <= ST_RESP;
                            Done   <= 1'b1;
                            Err    <= 1'b0;
                            RamRWn <= 1'b1;
                            RamDin <= '0;
                        end else begin
                            beat    <= beat_nxt;
                            RamAddr <= addr_q + ADDR_W'(beat_nxt);
                            RamDin  <= beat_din(wdata_q, beat_nxt, split_q);
                        end
                    end else begin
                        state  <= ST_CAPTURE;
                        RamRWn <= 1'b1;
                        RamDin <= '0;
                    end
                end

                ST_CAPTURE: begin
                    asm_buf <= buf_next;
                    if (at_last) begin
                        state <= ST_RESP;
                        Done  <= 1'b1;
                        Err   <= 1'b0;
                        RData <= load_result;
                    end else begin
                        state   <= ST_ACCESS;
                        beat    <= beat_nxt;
                        RamAddr <= addr_q + ADDR_W'(beat_nxt);
                    end
                end

                default: begin
                    state <= ST_IDLE;
                    Ready <= 1'b1;
                    Err   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a byte-array RAM model
// (registered, lane-selected read; little-endian writes; address wraps).
module tb_mem_access_unit;

    localparam int ADDR_W = 9;
    localparam int DATA_W = 32;

    logic              clk;
    logic              rst;
    logic              req;
    logic              wr;
    logic [1:0]        size;
    logic              sgn;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              ready;
    logic              done;
    logic              err;
    logic [DATA_W-1:0] rdata;
    logic [ADDR_W-1:0] ram_addr;
    logic [1:0]        ram_mode;
    logic              ram_rwn;
    logic [DATA_W-1:0] ram_din;
    logic [DATA_W-1:0] ram_dout;

    int tests = 0;
    int fails = 0;

    mem_access_unit #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .CLK     (clk),
        .RST     (rst),
        .Req     (req),
        .Wr      (wr),
        .Size    (size),
        .Sgn     (sgn),
        .Addr    (addr),
        .WData   (wdata),
        .Ready   (ready),
        .Done    (done),
        .Err     (err),
        .RData   (rdata),
        .RamAddr (ram_addr),
        .RamMode (ram_mode),
        .RamRWn  (ram_rwn),
        .RamDin  (ram_din),
        .RamDout (ram_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model
    logic [7:0]        mem [0:511];
    logic [ADDR_W-1:0] a1, a2, a3;
    assign a1 = ram_addr + 9'd1;
    assign a2 = ram_addr + 9'd2;
    assign a3 = ram_addr + 9'd3;

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 512; i++) mem[i] <= 8'h00;
            ram_dout <= '0;
        end else begin
            if (!ram_rwn) begin
                case (ram_mode)
                    2'b01: mem[ram_addr] <= ram_din[7:0];
                    2'b10: begin
                        mem[ram_addr] <= ram_din[7:0];
                        mem[a1]       <= ram_din[15:8];
                    end
                    default: begin
                        mem[ram_addr] <= ram_din[7:0];
                        mem[a1]       <= ram_din[15:8];
                        mem[a2]       <= ram_din[23:16];
                        mem[a3]       <= ram_din[31:24];
                    end
                endcase
            end
            case (ram_mode)
                2'b01:   ram_dout <= {24'h0, mem[ram_addr]};
                2'b10:   ram_dout <= {16'h0, mem[a1], mem[ram_addr]};
                default: ram_dout <= {mem[a3], mem[a2], mem[a1], mem[ram_addr]};
            endcase
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one request; returns cycles from acceptance edge to Done
    // (-1 on timeout), plus RData/Err sampled in the Done cycle.
    task automatic do_access(input logic w, input logic [1:0] sz, input logic sg,
                             input logic [ADDR_W-1:0] ad, input logic [31:0] wd,
                             input logic hold,
                             output int cyc, output logic [31:0] rd, output logic er);
        int waited;
        cyc = -1;
        rd  = 'x;
        er  = 1'bx;
        @(negedge clk);
        waited = 0;
        while (!ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        req = 1'b1; wr = w; size = sz; sgn = sg; addr = ad; wdata = wd;
        @(posedge clk);
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (!hold) req = 1'b0;
            if (done) begin
                cyc = c;
                rd  = rdata;
                er  = err;
                req = 1'b0;
                break;
            end
        end
        req = 1'b0;
    endtask

    function automatic logic [31:0] mem_word(input logic [ADDR_W-1:0] a);
        logic [ADDR_W-1:0] b1, b2, b3;
        b1 = a + 9'd1; b2 = a + 9'd2; b3 = a + 9'd3;
        return {mem[b3], mem[b2], mem[b1], mem[a]};
    endfunction

    int          cyc;
    logic [31:0] rd;
    logic        er;
    int          extra;
    logic [ADDR_W-1:0] hold_addr;

    initial begin
        rst = 1'b1; req = 1'b0; wr = 1'b0; size = 2'b00; sgn = 1'b0;
        addr = '0; wdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_done",    {31'b0, done},      32'h0);
        check("rst_err",     {31'b0, err},       32'h0);
        check("rst_rdata",   rdata,              32'h0);
        check("rst_ramrwn",  {31'b0, ram_rwn},   32'h1);
        check("rst_ramaddr", {23'b0, ram_addr},  32'h0);
        check("rst_rammode", {30'b0, ram_mode},  32'h0);
        check("rst_ramdin",  ram_din,            32'h0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_ready",   {31'b0, ready},     32'h1);

        // Aligned word store then load
        do_access(1'b1, 2'b00, 1'b0, 9'h010, 32'hDEADBEEF, 1'b0, cyc, rd, er);
        check("st_word_cycles", cyc, 32'd2);
        check("st_word_err",    {31'b0, er}, 32'h0);
        check("st_word_rdata",  rd, 32'h0);
        check("st_word_mem",    mem_word(9'h010), 32'hDEADBEEF);
        do_access(1'b0, 2'b00, 1'b0, 9'h010, 32'h0, 1'b0, cyc, rd, er);
        check("ld_word_cycles", cyc, 32'd3);
        check("ld_word_rdata",  rd, 32'hDEADBEEF);
        check("ld_word_err",    {31'b0, er}, 32'h0);

        // Byte and half stores set up 0x11=80, 0x12..13=8001
        do_access(1'b1, 2'b01, 1'b0, 9'h011, 32'h00000080, 1'b0, cyc, rd, er);
        check("st_byte_cycles", cyc, 32'd2);
        check("st_byte_rdata",  rd, 32'hDEADBEEF);
        do_access(1'b1, 2'b10, 1'b0, 9'h012, 32'h00008001, 1'b0, cyc, rd, er);
        check("st_half_cycles", cyc, 32'd2);
        check("st_half_mem",    mem_word(9'h010), 32'h800180EF);

        do_access(1'b0, 2'b01, 1'b1, 9'h011, 32'h0, 1'b0, cyc, rd, er);
        check("ld_byte_s_cycles", cyc, 32'd3);
        check("ld_byte_s",  rd, 32'hFFFFFF80);
        do_access(1'b0, 2'b01, 1'b0, 9'h011, 32'h0, 1'b0, cyc, rd, er);
        check("ld_byte_u",  rd, 32'h00000080);
        do_access(1'b0, 2'b10, 1'b1, 9'h012, 32'h0, 1'b0, cyc, rd, er);
        check("ld_half_s",  rd, 32'hFFFF8001);
        do_access(1'b0, 2'b10, 1'b0, 9'h012, 32'h0, 1'b0, cyc, rd, er);
        check("ld_half_u",  rd, 32'h00008001);
        do_access(1'b0, 2'b00, 1'b1, 9'h010, 32'h0, 1'b0, cyc, rd, er);
        check("ld_word_sgn", rd, 32'h800180EF);
        do_access(1'b0, 2'b11, 1'b0, 9'h010, 32'h0, 1'b0, cyc, rd, er);
        check("ld_size11",  rd, 32'h800180EF);

        // Misaligned word store across the top of the address space
        do_access(1'b1, 2'b00, 1'b0, 9'h1FE, 32'h11223344, 1'b0, cyc, rd, er);
`ifdef MAU_SPLIT_EN
        check("mis_st_cycles", cyc, 32'd5);
        check("mis_st_err",    {31'b0, er}, 32'h0);
        check("mis_st_1fe",    {24'b0, mem[9'h1FE]}, 32'h44);
        check("mis_st_1ff",    {24'b0, mem[9'h1FF]}, 32'h33);
        check("mis_st_000",    {24'b0, mem[9'h000]}, 32'h22);
        check("mis_st_001",    {24'b0, mem[9'h001]}, 32'h11);
        check("mis_st_rdata",  rd, 32'h800180EF);
        do_access(1'b0, 2'b00, 1'b0, 9'h1FE, 32'h0, 1'b0, cyc, rd, er);
        check("mis_ld_cycles", cyc, 32'd9);
        check("mis_ld_rdata",  rd, 32'h11223344);
        check("mis_ld_err",    {31'b0, er}, 32'h0);
        do_access(1'b0, 2'b10, 1'b1, 9'h1FF, 32'h0, 1'b0, cyc, rd, er);
        check("mis_ldh_cycles", cyc, 32'd5);
        check("mis_ldh_rdata",  rd, 32'h00002233);
        hold_addr = 9'h101;
`else
        check("mis_st_cycles", cyc, 32'd1);
        check("mis_st_err",    {31'b0, er}, 32'h1);
        check("mis_st_mem",    mem_word(9'h1FE), 32'h0);
        check("mis_st_rdata",  rd, 32'h800180EF);
        do_access(1'b0, 2'b10, 1'b1, 9'h1FF, 32'h0, 1'b0, cyc, rd, er);
        check("mis_ldh_cycles", cyc, 32'd1);
        check("mis_ldh_err",    {31'b0, er}, 32'h1);
        check("mis_ldh_rdata",  rd, 32'h800180EF);
        hold_addr = 9'h100;
`endif

        // Req held high while busy: one Done, no re-acceptance
        do_access(1'b1, 2'b00, 1'b0, hold_addr, 32'hA5C31E96, 1'b1, cyc, rd, er);
`ifdef MAU_SPLIT_EN
        check("hold_cycles", cyc, 32'd5);
`else
        check("hold_cycles", cyc, 32'd2);
`endif
        extra = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (done) extra++;
        end
        check("hold_extra_done", extra, 32'd0);
        check("hold_mem", mem_word(hold_addr), 32'hA5C31E96);
        check("hold_ready", {31'b0, ready}, 32'h1);

        // Reset during CAPTURE of a load
        @(negedge clk);
        req = 1'b1; wr = 1'b0; size = 2'b00; sgn = 1'b0; addr = 9'h010;
        @(posedge clk);
        @(negedge clk);
        req = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rstcap_done",  {31'b0, done},  32'h0);
        check("rstcap_ready", {31'b0, ready}, 32'h1);
        check("rstcap_rdata", rdata, 32'h0);
        rst = 1'b0;
        extra = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (done) extra++;
        end
        check("rstcap_no_done", extra, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 9, the RAM byte-address width.
REQ-002 SHALL have parameter DATA_W, default 32, the data width; only 32 is supported.
REQ-003 CLK  in  1  clock; all state changes on the rising edge.
REQ-004 RST  in  1  reset; synchronous, active-high.
REQ-005 Req  in  1  CPU access request.
REQ-006 Wr  in  1  1 = store, 0 = load.
REQ-007 Size  in  2  00 word, 01 byte, 10 half, 11 treated as word.
REQ-008 Sgn  in  1  sign-extend byte/half loads.
REQ-009 Addr  in  ADDR_W  byte address.
REQ-010 WData  in  32  store data, right-justified.
REQ-011 Ready  out  1  idle and accepting a request.
REQ-012 Done  out  1  one-cycle completion pulse.
REQ-013 Err  out  1  misalignment error, valid with Done.
REQ-014 RData  out  32  load result, valid from Done until the next Done.
REQ-015 RamAddr  out  ADDR_W  RAM byte address.
REQ-016 RamMode  out  2  RAM mode, same encoding as Size.
REQ-017 RamRWn  out  1  RAM write enable, 0 = write.
REQ-018 RamDin  out  32  RAM write data.
REQ-019 RamDout  in  32  RAM read data, registered, one cycle after the address edge, lane-selected by the RAM.

Function
REQ-020 SHALL accept a request at a rising edge where Req=1 and Ready=1, latching Wr/Size/Sgn/Addr/WData; Req SHALL be ignored while Ready=0.
REQ-021 SHALL implement states IDLE, ACCESS, CAPTURE, RESP; Ready=1 only in IDLE.
REQ-022 IDLE SHALL go to ACCESS on acceptance, or to RESP with Err=1 and no RAM access when misaligned and the split feature is absent.
REQ-023 Misaligned SHALL mean word with Addr[1:0]!=00, or half with Addr[0]=1.
REQ-024 ACCESS SHALL drive RamAddr, RamMode and RamDin for beat k; RamRWn SHALL be 0 for a store and 1 for a load.
REQ-025 A store in ACCESS SHALL go to RESP after its last beat; otherwise k increments and the unit stays in ACCESS.
REQ-026 A load in ACCESS SHALL go to CAPTURE.
REQ-027 CAPTURE SHALL hold RamAddr/RamMode unchanged with RamRWn=1 and register RamDout into the assembly buffer.
REQ-028 CAPTURE SHALL go to RESP after the last beat, else to ACCESS with k+1.
REQ-029 RESP SHALL assert Done for exactly one cycle, update RData for loads, set Err, and return to IDLE.
REQ-030 RAM outputs: RamRWn SHALL be 1 in every state other than a store ACCESS, and RamDin SHALL be 0 outside ACCESS.
REQ-031 An aligned load SHALL assert Done in the 3rd cycle after the acceptance edge; an aligned store in the 2nd.
REQ-032 Load results SHALL be zero-extended when Sgn=0 and sign-extended from bit 7 (byte) or bit 15 (half) when Sgn=1; word loads are unaffected by Sgn.
REQ-033 RData SHALL be unchanged on store completion and on error completion.

Reset
REQ-034 With RST=1 at an edge, the unit SHALL go to IDLE, including mid-operation, abandoning any remaining beats with no Done for them.
REQ-035 Reset values: Done=0, Err=0, RData=0, RamRWn=1, RamAddr=0, RamMode=00, RamDin=0; Ready=1 from the first cycle after RST deasserts.

Configuration
REQ-036 With MAU_SPLIT_EN defined, a misaligned access SHALL execute as N byte beats (N=4 word, N=2 half) at Addr+k modulo 2^ADDR_W, little-endian: beat k carries byte k of WData and fills byte k of RData, with Err=0.
REQ-037 Without MAU_SPLIT_EN, a misaligned access SHALL complete via RESP with Err=1 one cycle after acceptance, with no RAM write.

Structure
REQ-038 The shared package mau_pkg SHALL hold the size encodings, the state enumeration and the maximum beat count.
REQ-039 Sub-module mau_load_align SHALL be instantiated; it performs byte placement into the assembly buffer and final zero/sign extension.

Verification
REQ-040 Aligned word store of 0xDEADBEEF to 0x10, then word load from 0x10 -> RData=0xDEADBEEF; store Done at cycle 2, load Done at cycle 3.
REQ-041 Byte load from 0x11 holding 0x80: with Sgn=1 -> 0xFFFFFF80; with Sgn=0 -> 0x00000080.
REQ-042 Half load at 0x12 holding 0x8001 with Sgn=1 -> 0xFFFF8001.
REQ-043 Word store 0x11223344 to 0x1FE with ADDR_W=9: with MAU_SPLIT_EN, bytes 44/33/22/11 land at 0x1FE/0x1FF/0x000/0x001 and Done occurs at cycle 5; without it, Err=1 and memory is unchanged.
REQ-044 RST asserted in the CAPTURE cycle of a load -> no Done, Ready=1 the following cycle, RData=0.
REQ-045 Req held high during a busy split access -> exactly one Done per accepted request, with no extra acceptance.
